mpeg_stream_sink: RTL and testbench

//  Receiving end of the MPEG byte-stream interface (data + enable + stream_end + prog_full).

---
 rtl/mpeg_stream_sink_pkg.sv | 15 +
 rtl/mpeg_stream_sink_if.sv | 23 ++
 rtl/mpeg_stream_sink_fifo.sv | 50 +++++
 rtl/mpeg_stream_sink.sv | 76 +++++++
 tb/tb_mpeg_stream_sink.sv | 234 +++++++++++++++++++++++
 5 files changed

// File: rtl/mpeg_stream_sink_pkg.sv
// Shared constants for the MPEG byte-stream sink and its FIFO.
// Also holds the pointer-width helper used by the input-side FIFO.
package mpeg_stream_pkg;

  localparam int BYTE_W               = 8;
  localparam int DEF_DEPTH            = 64;
  localparam int DEF_PROG_FULL_THRESH = 56;
  localparam int DEF_CNT_W            = 32;

  // One extra MSB lets full and empty be told apart when the index bits match.
  function automatic int ptr_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/mpeg_stream_sink_if.sv
// Byte-stream input (data/enable/end/prog_full) and valid/ready output of the sink.
interface mpeg_stream_if;
  import mpeg_stream_pkg::*;

  logic [BYTE_W-1:0] mpeg_in;
  logic              mpeg_in_en;
  logic              stream_end;
  logic              mpeg_prog_full;
  logic [BYTE_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;

  modport master (
    output mpeg_in, mpeg_in_en, stream_end, out_ready,
    input  mpeg_prog_full, out_data, out_valid
  );

  modport slave (
    input  mpeg_in, mpeg_in_en, stream_end, out_ready,
    output mpeg_prog_full, out_data, out_valid
  );

endinterface

// File: rtl/mpeg_stream_sink_fifo.sv
// First-word-fall-through synchronous byte FIFO with occupancy count.
module mpeg_byte_fifo
  import mpeg_stream_pkg::*;
#(
  parameter  int DEPTH = DEF_DEPTH,
  localparam int PW    = ptr_width(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_push,
  input  logic [BYTE_W-1:0] i_data,
  input  logic              i_pop,
  output logic [BYTE_W-1:0] o_data,
  output logic              o_empty,
  output logic              o_full,
  output logic [PW-1:0]     o_count
);

  localparam int AW = PW - 1;

  logic [BYTE_W-1:0] r_mem [DEPTH];
  logic [PW-1:0]     r_wr_ptr;
  logic [PW-1:0]     r_rd_ptr;
  logic              w_push;
  logic              w_pop;

  assign o_empty = (r_wr_ptr == r_rd_ptr);
  assign o_full  = (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]) && (r_wr_ptr[AW] != r_rd_ptr[AW]);
  assign o_count = r_wr_ptr - r_rd_ptr;
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;

  // Head byte is read combinationally; forced to zero when nothing is buffered.
  assign o_data = o_empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= i_data;
  end

endmodule

// File: rtl/mpeg_stream_sink.sv
// Receiving end of the MPEG byte stream: buffers bytes, drains over valid/ready,
// back-pressures with prog_full and reports done/overflow/late-byte status.
module mpeg_stream_sink
  import mpeg_stream_pkg::*;
#(
  parameter int DEPTH            = DEF_DEPTH,
  parameter int PROG_FULL_THRESH = DEF_PROG_FULL_THRESH,
  parameter int CNT_W            = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  mpeg_stream_if.slave     bus,
  output logic             o_done,
  output logic             o_overflow,
  output logic             o_late_byte,
  output logic [CNT_W-1:0] o_byte_in_cnt,
  output logic [CNT_W-1:0] o_byte_out_cnt
);

  localparam int PW = ptr_width(DEPTH);

  // The producer reacts to prog_full a cycle late, so two slots of headroom are needed.
  if (((DEPTH & (DEPTH - 1)) != 0) || (DEPTH < 4) || (PROG_FULL_THRESH > DEPTH - 2)) begin : g_param_check
    $error("mpeg_stream_sink: DEPTH must be a power of 2 >= 4 and PROG_FULL_THRESH <= DEPTH-2");
  end

  logic          w_full;
  logic          w_empty;
  logic          w_push;
  logic          w_pop;
  logic [PW-1:0] w_count;
  logic [PW-1:0] w_next_count;
  logic          r_end_seen;
  logic          r_prog_full;

  assign w_push       = bus.mpeg_in_en && !w_full;
  assign w_pop        = !w_empty && bus.out_ready;
  assign w_next_count = w_count + PW'(w_push) - PW'(w_pop);

  mpeg_byte_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_data  (bus.mpeg_in),
    .i_pop   (w_pop),
    .o_data  (bus.out_data),
    .o_empty (w_empty),
    .o_full  (w_full),
    .o_count (w_count)
  );

  assign bus.out_valid      = !w_empty;
  assign bus.mpeg_prog_full = r_prog_full;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_end_seen     <= 1'b0;
      r_prog_full    <= 1'b0;
      o_done         <= 1'b0;
      o_overflow     <= 1'b0;
      o_late_byte    <= 1'b0;
      o_byte_in_cnt  <= '0;
      o_byte_out_cnt <= '0;
    end else begin
      r_end_seen  <= r_end_seen | bus.stream_end;
      r_prog_full <= (w_next_count >= PW'(PROG_FULL_THRESH));
      if (bus.mpeg_in_en && w_full)     o_overflow  <= 1'b1;
      if (bus.mpeg_in_en && r_end_seen) o_late_byte <= 1'b1;
      // A byte arriving this cycle keeps done low until it has drained.
      if (r_end_seen && w_empty && !bus.mpeg_in_en) o_done <= 1'b1;
      if (w_push) o_byte_in_cnt  <= o_byte_in_cnt + CNT_W'(1);
      if (w_pop)  o_byte_out_cnt <= o_byte_out_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_mpeg_stream_sink.sv
// Self-checking bench for mpeg_stream_sink: queue-based reference model plus directed checks.
module tb_mpeg_stream_sink;
  import mpeg_stream_pkg::*;

  localparam int DEPTH  = 64;
  localparam int THRESH = 56;
  localparam int CNT_W  = 32;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             done;
  logic             overflow;
  logic             lateByte;
  logic [CNT_W-1:0] inCnt;
  logic [CNT_W-1:0] outCnt;

  int checkCount = 0;
  int passCount  = 0;

  mpeg_stream_if bus();

  mpeg_stream_sink #(
    .DEPTH            (DEPTH),
    .PROG_FULL_THRESH (THRESH),
    .CNT_W            (CNT_W)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .bus            (bus),
    .o_done         (done),
    .o_overflow     (overflow),
    .o_late_byte    (lateByte),
    .o_byte_in_cnt  (inCnt),
    .o_byte_out_cnt (outCnt)
  );

  always #5 clk = ~clk;

  // Reference model: a byte queue plus sticky flags, advanced on every rising edge.
  logic [7:0]       mQ[$];
  logic [CNT_W-1:0] mInCnt;
  logic [CNT_W-1:0] mOutCnt;
  bit mOverflow, mLate, mEndSeen, mDone, mProgFull;
  bit modelValid = 1'b0;

  always @(posedge clk) begin : model
    bit wasFull, wasEmpty, doneCond;
    if (!rst_n) begin
      mQ.delete();
      mInCnt = '0; mOutCnt = '0;
      mOverflow = 0; mLate = 0; mEndSeen = 0; mDone = 0; mProgFull = 0;
      modelValid = 1'b1;
    end else begin
      wasFull  = (mQ.size() == DEPTH);
      wasEmpty = (mQ.size() == 0);
      doneCond = mEndSeen && wasEmpty && !bus.mpeg_in_en;
      if (!wasEmpty && bus.out_ready) begin
        void'(mQ.pop_front());
        mOutCnt = mOutCnt + 1;
      end
      if (bus.mpeg_in_en) begin
        if (mEndSeen) mLate = 1;
        if (wasFull) mOverflow = 1;
        else begin
          mQ.push_back(bus.mpeg_in);
          mInCnt = mInCnt + 1;
        end
      end
      if (bus.stream_end) mEndSeen = 1;
      if (doneCond) mDone = 1;
      mProgFull = (mQ.size() >= THRESH);
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual === expected) passCount++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
  endtask

  always @(negedge clk) begin
    if (modelValid) begin
      checkOutput("cyc_out_valid", bus.out_valid, (mQ.size() != 0));
      if (mQ.size() != 0) checkOutput("cyc_out_data", bus.out_data, mQ[0]);
      checkOutput("cyc_prog_full", bus.mpeg_prog_full, mProgFull);
      checkOutput("cyc_done", done, mDone);
      checkOutput("cyc_overflow", overflow, mOverflow);
      checkOutput("cyc_late_byte", lateByte, mLate);
      checkOutput("cyc_in_cnt", inCnt, mInCnt);
      checkOutput("cyc_out_cnt", outCnt, mOutCnt);
    end
  end

  task automatic applyStimulus(input logic en, input logic [7:0] data, input logic endFlag, input logic rdy);
    bus.mpeg_in_en = en;
    bus.mpeg_in    = data;
    bus.stream_end = endFlag;
    bus.out_ready  = rdy;
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
    rst_n = 1'b1;
  endtask

  int   waited;
  int   sent;
  logic rndEn;
  logic rndRdy;

  initial begin
    rst_n          = 1'b0;
    bus.mpeg_in    = '0;
    bus.mpeg_in_en = 1'b0;
    bus.stream_end = 1'b0;
    bus.out_ready  = 1'b0;

    // Reset state and in-order pass-through with the sink always ready
    doReset();
    checkOutput("rst_out_valid", bus.out_valid, 0);
    checkOutput("rst_out_data", bus.out_data, 0);
    checkOutput("rst_prog_full", bus.mpeg_prog_full, 0);
    checkOutput("rst_done", done, 0);
    checkOutput("rst_in_cnt", inCnt, 0);
    checkOutput("rst_out_cnt", outCnt, 0);
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b1, 8'(i), 1'b0, 1'b1);
      checkOutput("t1_valid", bus.out_valid, 1);
      checkOutput("t1_data", bus.out_data, i);
    end
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
    checkOutput("t1_in_cnt", inCnt, 10);
    checkOutput("t1_out_cnt", outCnt, 10);
    checkOutput("t1_overflow", overflow, 0);
    checkOutput("t1_drained", bus.out_valid, 0);

    // Fill to the threshold, then to full, then one byte past full
    doReset();
    for (int i = 0; i < 55; i++) applyStimulus(1'b1, 8'(i), 1'b0, 1'b0);
    checkOutput("t2_pf_at_55", bus.mpeg_prog_full, 0);
    applyStimulus(1'b1, 8'd55, 1'b0, 1'b0);
    checkOutput("t2_pf_at_56", bus.mpeg_prog_full, 1);
    for (int i = 56; i < 64; i++) applyStimulus(1'b1, 8'(i), 1'b0, 1'b0);
    checkOutput("t2_in_cnt_64", inCnt, 64);
    checkOutput("t2_model_size_64", mQ.size(), 64);
    checkOutput("t2_no_overflow_yet", overflow, 0);
    applyStimulus(1'b1, 8'hEE, 1'b0, 1'b0);
    checkOutput("t2_overflow", overflow, 1);
    checkOutput("t2_in_cnt_held", inCnt, 64);

    // Push and pop together on a full FIFO: the push is dropped
    doReset();
    for (int i = 0; i < 64; i++) applyStimulus(1'b1, 8'(i), 1'b0, 1'b0);
    checkOutput("t3_pre_overflow", overflow, 0);
    applyStimulus(1'b1, 8'hAA, 1'b0, 1'b1);
    checkOutput("t3_overflow", overflow, 1);
    checkOutput("t3_out_cnt", outCnt, 1);
    checkOutput("t3_in_cnt", inCnt, 64);
    checkOutput("t3_model_size_63", mQ.size(), 63);
    checkOutput("t3_head", bus.out_data, 1);
    checkOutput("t3_prog_full", bus.mpeg_prog_full, 1);

    // stream_end with the last byte: done rises one cycle after empty
    doReset();
    applyStimulus(1'b1, 8'h11, 1'b0, 1'b1);
    applyStimulus(1'b1, 8'h22, 1'b0, 1'b1);
    applyStimulus(1'b1, 8'h33, 1'b1, 1'b1);
    checkOutput("t4_done_early", done, 0);
    waited = 0;
    while (bus.out_valid && waited < 20) begin
      applyStimulus(1'b0, 8'h00, 1'b1, 1'b1);
      waited++;
    end
    checkOutput("t4_drain_cycles", waited, 1);
    checkOutput("t4_done_at_empty", done, 0);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b1);
    checkOutput("t4_done_rise", done, 1);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 8'h00, 1'b1, 1'b1);
      checkOutput("t4_done_sticky", done, 1);
    end

    // A late byte is flagged but still delivered; done stays set
    applyStimulus(1'b1, 8'h44, 1'b1, 1'b1);
    checkOutput("t5_late", lateByte, 1);
    checkOutput("t5_valid", bus.out_valid, 1);
    checkOutput("t5_data", bus.out_data, 8'h44);
    checkOutput("t5_done_held", done, 1);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b1);
    checkOutput("t5_in_cnt", inCnt, 4);
    checkOutput("t5_out_cnt", outCnt, 4);
    checkOutput("t5_done_still", done, 1);

    // Reset with 20 bytes buffered discards everything
    doReset();
    for (int i = 0; i < 20; i++) applyStimulus(1'b1, 8'(i + 100), 1'b0, 1'b0);
    checkOutput("t6_in_cnt_20", inCnt, 20);
    doReset();
    checkOutput("t6_valid", bus.out_valid, 0);
    checkOutput("t6_data", bus.out_data, 0);
    checkOutput("t6_prog_full", bus.mpeg_prog_full, 0);
    checkOutput("t6_done", done, 0);
    checkOutput("t6_late", lateByte, 0);
    checkOutput("t6_in_cnt", inCnt, 0);
    checkOutput("t6_out_cnt", outCnt, 0);

    // Random 5000-byte stream honouring prog_full, then end and drain
    sent = 0;
    for (int cyc = 0; cyc < 30000 && sent < 5000; cyc++) begin
      rndEn  = !bus.mpeg_prog_full && ($urandom_range(0, 3) != 0);
      rndRdy = ($urandom_range(0, 3) != 0);
      applyStimulus(rndEn, 8'($urandom), 1'b0, rndRdy);
      if (rndEn) sent++;
    end
    checkOutput("t6_stream_sent", sent, 5000);
    waited = 0;
    while (!done && waited < 300) begin
      applyStimulus(1'b0, 8'h00, 1'b1, 1'b1);
      waited++;
    end
    checkOutput("t6_stream_done", done, 1);
    checkOutput("t6_stream_in_cnt", inCnt, 5000);
    checkOutput("t6_stream_out_cnt", outCnt, 5000);
    checkOutput("t6_stream_overflow", overflow, 0);

    @(negedge clk);
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
